// File: rtl/mandelbrot_iter_engine_if.sv
// rtl/mandelbrot_iter_engine_if.sv - point-in / result-out handshake bundle for the Mandelbrot iteration engine
interface mandelbrot_iter_engine_if #(
    parameter int WORD_LENGTH = 16,
    parameter int ITER_W      = 10
);
    logic                          c_valid;
    logic                          c_ready;
    logic signed [WORD_LENGTH-1:0] c_real;
    logic signed [WORD_LENGTH-1:0] c_imag;
    logic [10:0]                   x_in;
    logic [10:0]                   y_in;
    logic [ITER_W-1:0]             max_iter;

    logic                          out_valid;
    logic                          out_ready;
    logic [ITER_W-1:0]             iter_count;
    logic                          escaped;
    logic [10:0]                   x_out;
    logic [10:0]                   y_out;

    modport master (
        output c_valid, c_real, c_imag, x_in, y_in, max_iter, out_ready,
        input  c_ready, out_valid, iter_count, escaped, x_out, y_out
    );

    modport slave (
        input  c_valid, c_real, c_imag, x_in, y_in, max_iter, out_ready,
        output c_ready, out_valid, iter_count, escaped, x_out, y_out
    );
endinterface

// File: rtl/mandelbrot_iter_engine.sv
// rtl/mandelbrot_iter_engine.sv - one-point-at-a-time z = z^2 + c escape-time engine
// Optional macro CARDIOID_SKIP_EN: short-circuit points inside the period-2 bulb at accept.
module mandelbrot_iter_engine #(
    parameter int WORD_LENGTH = 16,
    parameter int FRAC        = 8,
    parameter int ITER_W      = 10
) (
    input logic                      clk,
    input logic                      rst_n,
    mandelbrot_iter_engine_if.slave  bus
);
    localparam int DW = 2 * WORD_LENGTH;

    // Escape radius 2 squared, in the FRAC-scaled domain of the shifted products.
    localparam logic signed [DW:0] ESC_LIM = (DW + 1)'(4) <<< FRAC;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t state_q, state_d;

    logic signed [WORD_LENGTH-1:0] cr_q, ci_q, zr_q, zi_q;
    logic [ITER_W-1:0]             iter_q, max_q, count_q;
    logic                          esc_q;
    logic [10:0]                   x_q, y_q;

    logic signed [DW-1:0] zr_x, zi_x, sq_r, sq_i, x_ri;
    logic signed [DW:0]   mag;
    logic                 escape, at_limit, accept, bulb;
    logic signed [WORD_LENGTH-1:0] zr_next, zi_next;

    assign zr_x = DW'(zr_q);
    assign zi_x = DW'(zi_q);
    assign sq_r = (zr_x * zr_x) >>> FRAC;
    assign sq_i = (zi_x * zi_x) >>> FRAC;
    assign x_ri = (zr_x * zi_x) >>> FRAC;

    assign mag      = (DW + 1)'(sq_r) + (DW + 1)'(sq_i);
    assign escape   = mag > ESC_LIM;
    assign at_limit = (iter_q == max_q);

    assign zr_next = WORD_LENGTH'(sq_r - sq_i + DW'(cr_q));
    assign zi_next = WORD_LENGTH'((x_ri <<< 1) + DW'(ci_q));

    assign accept = (state_q == IDLE) && bus.c_valid;

`ifdef CARDIOID_SKIP_EN
    localparam logic signed [DW-1:0] ONE_X    = DW'(1) <<< FRAC;
    localparam logic signed [DW-1:0] BULB_LIM = DW'(1) <<< (2 * FRAC - 4);
    logic signed [DW-1:0] b_r, b_i;
    assign b_r  = DW'(bus.c_real) + ONE_X;
    assign b_i  = DW'(bus.c_imag);
    assign bulb = ((b_r * b_r) + (b_i * b_i)) < BULB_LIM;
`else
    assign bulb = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.c_ready   = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.c_ready = 1'b1;
                if (bus.c_valid) begin
                    state_d = bulb ? DONE : ITER;
                end
            end
            ITER: begin
                if (escape || at_limit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_q    <= '0;
            ci_q    <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            iter_q  <= '0;
            max_q   <= '0;
            count_q <= '0;
            esc_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (accept) begin
            cr_q   <= bus.c_real;
            ci_q   <= bus.c_imag;
            x_q    <= bus.x_in;
            y_q    <= bus.y_in;
            max_q  <= bus.max_iter;
            zr_q   <= '0;
            zi_q   <= '0;
            iter_q <= '0;
            if (bulb) begin
                count_q <= bus.max_iter;
                esc_q   <= 1'b0;
            end
        end else if (state_q == ITER) begin
            if (escape) begin
                count_q <= iter_q;
                esc_q   <= 1'b1;
            end else if (at_limit) begin
                count_q <= iter_q;
                esc_q   <= 1'b0;
            end else begin
                zr_q   <= zr_next;
                zi_q   <= zi_next;
                iter_q <= iter_q + 1'b1;
            end
        end
    end

    assign bus.iter_count = count_q;
    assign bus.escaped    = esc_q;
    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// tb/tb_mandelbrot_iter_engine.sv - table, corner-case and randomized checks of mandelbrot_iter_engine
module tb_mandelbrot_iter_engine;
    logic clk;
    logic rst_n;

    mandelbrot_iter_engine_if #(.WORD_LENGTH(16), .ITER_W(10)) bus ();

    mandelbrot_iter_engine #(.WORD_LENGTH(16), .FRAC(8), .ITER_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint wrap16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return longint'(t);
    endfunction

    // Escape-time reference in plain integer arithmetic; lat counts edges after the accepting edge.
    task automatic model(input int cr, input int ci, input int maxit,
                         output int cnt, output int esc, output int lat);
        longint zr, zi, rr, ii, ri;
        int it;
        zr = 0; zi = 0; it = 0;
`ifdef CARDIOID_SKIP_EN
        if ((longint'(cr) + 256) * (longint'(cr) + 256) + longint'(ci) * ci < 4096) begin
            cnt = maxit; esc = 0; lat = 0;
            return;
        end
`endif
        forever begin
            rr = (zr * zr) >>> 8;
            ii = (zi * zi) >>> 8;
            ri = (zr * zi) >>> 8;
            if (rr + ii > 1024) begin
                cnt = it; esc = 1; break;
            end
            if (it == maxit) begin
                cnt = it; esc = 0; break;
            end
            zr = wrap16(rr - ii + cr);
            zi = wrap16(2 * ri + ci);
            it++;
        end
        lat = cnt + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offers one point, scrambles the inputs after accept, waits for the result and leaves it held in DONE.
    task automatic run_point(input int cr, input int ci, input int maxit, input int x, input int y,
                             output int cnt, output int esc, output int xo, output int yo,
                             output int lat, output bit ok);
        @(negedge clk);
        bus.c_real   = 16'(cr);
        bus.c_imag   = 16'(ci);
        bus.x_in     = 11'(x);
        bus.y_in     = 11'(y);
        bus.max_iter = 10'(maxit);
        bus.c_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.c_valid  = 1'b0;
        bus.c_real   = 16'($urandom);
        bus.c_imag   = 16'($urandom);
        bus.x_in     = 11'($urandom);
        bus.y_in     = 11'($urandom);
        bus.max_iter = 10'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 1100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok  = bus.out_valid;
        cnt = int'(bus.iter_count);
        esc = int'(bus.escaped);
        xo  = int'(bus.x_out);
        yo  = int'(bus.y_out);
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("c_ready_after_consume", bus.c_ready, 1);
    endtask

    typedef struct {
        int    cr;
        int    ci;
        int    maxit;
        int    x;
        int    y;
        int    exp_cnt;
        int    exp_esc;
        int    exp_lat;
        string name;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cnt, esc, xo, yo, lat;
        int m_cnt, m_esc, m_lat;
        int cr, ci, mi;
        bit ok;
        int held_cnt, held_esc, held_x, held_y;

        tbl[0] = '{0,    0,   100, 1,   2,   100, 0, 101, "origin"};
        tbl[1] = '{640,  0,   100, 3,   4,   1,   1, 2,   "c_2p5"};
        tbl[2] = '{256,  0,   100, 5,   6,   3,   1, 4,   "c_1p0_boundary"};
`ifdef CARDIOID_SKIP_EN
        tbl[3] = '{-256, 0,   50,  7,   8,   50,  0, 0,   "bulb_skip"};
`else
        tbl[3] = '{-256, 0,   50,  7,   8,   50,  0, 51,  "bulb_iterate"};
`endif
        tbl[4] = '{128,  64,  0,   9,   10,  0,   0, 1,   "max_iter_zero"};
        tbl[5] = '{640,  0,   20,  639, 479, 1,   1, 2,   "tag_capture"};

        rst_n         = 1'b0;
        bus.c_valid   = 1'b0;
        bus.c_real    = '0;
        bus.c_imag    = '0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.max_iter  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_c_ready", bus.c_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_iter_count", bus.iter_count, 0);
        check("reset_escaped", bus.escaped, 0);
        check("reset_x_out", bus.x_out, 0);
        check("reset_y_out", bus.y_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_point(tbl[i].cr, tbl[i].ci, tbl[i].maxit, tbl[i].x, tbl[i].y,
                      cnt, esc, xo, yo, lat, ok);
            check({tbl[i].name, "_valid"}, ok, 1);
            check({tbl[i].name, "_iter_count"}, cnt, tbl[i].exp_cnt);
            check({tbl[i].name, "_escaped"}, esc, tbl[i].exp_esc);
            check({tbl[i].name, "_latency"}, lat, tbl[i].exp_lat);
            check({tbl[i].name, "_x_out"}, xo, tbl[i].x);
            check({tbl[i].name, "_y_out"}, yo, tbl[i].y);
            if (!ok) do_reset();
            else release_result();
        end

        // Result held under backpressure with a competing point offered.
        run_point(640, 0, 30, 100, 200, cnt, esc, xo, yo, lat, ok);
        check("hold_valid", ok, 1);
        held_cnt = cnt; held_esc = esc; held_x = xo; held_y = yo;
        @(negedge clk);
        bus.c_real  = 16'sd0;
        bus.c_imag  = 16'sd0;
        bus.x_in    = 11'd5;
        bus.y_in    = 11'd5;
        bus.c_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_c_ready", bus.c_ready, 0);
            check("hold_iter_count", bus.iter_count, held_cnt);
            check("hold_escaped", bus.escaped, held_esc);
            check("hold_x_out", bus.x_out, held_x);
            check("hold_y_out", bus.y_out, held_y);
        end
        bus.c_valid = 1'b0;
        release_result();

        // Asynchronous reset in the middle of a long run.
        @(negedge clk);
        bus.c_real   = 16'sd0;
        bus.c_imag   = 16'sd0;
        bus.max_iter = 10'd100;
        bus.c_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.c_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_c_ready", bus.c_ready, 1);
        check("async_rst_iter_count", bus.iter_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_point(640, 0, 100, 11, 12, cnt, esc, xo, yo, lat, ok);
        check("post_rst_valid", ok, 1);
        check("post_rst_iter_count", cnt, 1);
        check("post_rst_escaped", esc, 1);
        check("post_rst_latency", lat, 2);
        if (!ok) do_reset();
        else release_result();

        // Randomized points against the escape-time reference.
        for (int n = 0; n < 40; n++) begin
            cr = $urandom_range(1280) - 640;
            ci = $urandom_range(1024) - 512;
            mi = $urandom_range(60);
            model(cr, ci, mi, m_cnt, m_esc, m_lat);
            run_point(cr, ci, mi, n, 2 * n, cnt, esc, xo, yo, lat, ok);
            check("rand_valid", ok, 1);
            check("rand_iter_count", cnt, m_cnt);
            check("rand_escaped", esc, m_esc);
            check("rand_latency", lat, m_lat);
            check("rand_x_out", xo, n);
            if (!ok) do_reset();
            else release_result();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
